// File: rtl/alu_defs_pkg.sv
// alu_defs_pkg: opcodes, FSM encodings and counter sizing shared by the
// sequential ALU files.
package alu_defs_pkg;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_MUL = 5'd3;
    localparam logic [4:0] OP_DIV = 5'd4;
    localparam logic [4:0] OP_SHL = 5'd5;
    localparam logic [4:0] OP_SHR = 5'd6;
    localparam logic [4:0] OP_AND = 5'd7;
    localparam logic [4:0] OP_OR  = 5'd8;
    localparam logic [4:0] OP_XOR = 5'd9;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // The counter only needs 0..w-1 because the last step is flagged combinationally.
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative unsigned shift-add multiplier and restoring divider,
// one bit per step; res/rem show the post-step value so the caller can latch on finish.
module seq_muldiv
    import alu_defs_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               finish,
    output logic [2*WIDTH-1:0] res,
    output logic [WIDTH-1:0]   rem
);
    localparam int CW = cnt_width(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d, mc_q, mc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d;
    logic [WIDTH:0]     rs, df;

    // Divide reuses acc as the partial remainder and mc as the fixed divisor.
    always_comb begin
        rs    = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        df    = rs - {1'b0, mc_q[WIDTH-1:0]};
        acc_d = acc_q;
        mc_d  = mc_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        div_d = div_q;
        if (load) begin
            acc_d = '0;
            mc_d  = {{WIDTH{1'b0}}, is_div ? b : a};
            q_d   = is_div ? a : b;
            cnt_d = '0;
            div_d = is_div;
        end else if (step) begin
            acc_d = div_q ? {{WIDTH{1'b0}}, df[WIDTH] ? rs[WIDTH-1:0] : df[WIDTH-1:0]}
                          : acc_q + (q_q[0] ? mc_q : '0);
            mc_d  = div_q ? mc_q : mc_q << 1;
            q_d   = div_q ? {q_q[WIDTH-2:0], ~df[WIDTH]} : q_q >> 1;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            mc_q  <= '0;
            q_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            mc_q  <= mc_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

    assign finish = step && cnt_q == CW'(WIDTH - 1);
    assign res    = div_q ? {{WIDTH{1'b0}}, q_d} : acc_d;
    assign rem    = div_q ? acc_d[WIDTH-1:0] : '0;
endmodule

// File: rtl/seq_alu_core.sv
// seq_alu_core: IDLE/RUN/DONE sequencer with single-cycle ops computed here
// and mul/div delegated to seq_muldiv.
module seq_alu_core
    import alu_defs_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [4:0]         op,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic [WIDTH-1:0]   remainder,
    output logic               carry,
    output logic               err
);
    localparam int SW = $clog2(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [2*WIDTH-1:0] result_q, result_d, md_res, sc_res;
    logic [WIDTH-1:0]   rem_q, rem_d, md_rem, sc_rem;
    logic               carry_q, carry_d, err_q, err_d, sc_carry, sc_err;
    logic               accept, long_op, md_finish;
    logic [WIDTH:0]     sum, dif;
    logic [SW-1:0]      sh;

    assign accept  = state_q == S_IDLE && start;
    assign long_op = op == OP_MUL || (op == OP_DIV && y != '0);

    // OP_DIV here only covers the divide-by-zero path; nonzero divisors go long.
    always_comb begin
        sum      = {1'b0, x} + {1'b0, y};
        dif      = {1'b0, x} - {1'b0, y};
        sh       = y[SW-1:0];
        sc_res   = '0;
        sc_rem   = '0;
        sc_carry = 1'b0;
        sc_err   = 1'b0;
        case (op)
            OP_ADD: begin
                sc_res   = {{(WIDTH-1){1'b0}}, sum};
                sc_carry = sum[WIDTH];
            end
            OP_SUB: begin
                sc_res   = {{WIDTH{1'b0}}, dif[WIDTH-1:0]};
                sc_carry = dif[WIDTH];
            end
            OP_MUL: begin
            end
            OP_DIV: begin
                sc_res = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                sc_rem = x;
                sc_err = 1'b1;
            end
            OP_SHL:  sc_res = {{WIDTH{1'b0}}, x << sh};
            OP_SHR:  sc_res = {{WIDTH{1'b0}}, x >> sh};
            OP_AND:  sc_res = {{WIDTH{1'b0}}, x & y};
            OP_OR:   sc_res = {{WIDTH{1'b0}}, x | y};
            OP_XOR:  sc_res = {{WIDTH{1'b0}}, x ^ y};
            default: sc_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        rem_d    = rem_q;
        carry_d  = carry_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = long_op ? S_RUN : S_DONE;
                if (!long_op) begin
                    result_d = sc_res;
                    rem_d    = sc_rem;
                    carry_d  = sc_carry;
                    err_d    = sc_err;
                end
            end
            S_RUN: if (md_finish) begin
                state_d  = S_DONE;
                result_d = md_res;
                rem_d    = md_rem;
                carry_d  = 1'b0;
                err_d    = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            rem_q    <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
        end
    end

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept && long_op),
        .step   (state_q == S_RUN),
        .is_div (op == OP_DIV),
        .a      (x),
        .b      (y),
        .finish (md_finish),
        .res    (md_res),
        .rem    (md_rem)
    );

    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign result    = result_q;
    assign remainder = rem_q;
    assign carry     = carry_q;
    assign err       = err_q;
endmodule
